// File: rtl/l1_arbiter.sv
// Round-robin arbiter merging icache fills and dcache fills/writebacks onto one L2 port.
// One transaction in flight; address/data latched at grant; response pulse one cycle after l2_resp.
module l1_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic                  d_wr_q, d_wr_d;
    logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
    logic [LINE_WIDTH-1:0] l2_wdata_q, l2_wdata_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  d_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            d_wr_q     <= 1'b0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            d_wr_q     <= d_wr_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        d_wr_d     = d_wr_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        d_pend     = d_read | d_write;
        case (state_q)
            IDLE: begin
                // On a tie the icache wins only if the dcache had the previous grant.
                if (i_read && (!d_pend || last_d_q)) begin
                    state_d   = SERVE_I;
                    last_d_d  = 1'b0;
                    l2_addr_d = i_addr;
                end else if (d_pend) begin
                    state_d    = SERVE_D;
                    last_d_d   = 1'b1;
                    l2_addr_d  = d_addr;
                    l2_wdata_d = d_wdata;
                    d_wr_d     = d_write;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    i_rdata_d = l2_rdata;
                    state_d   = RESP_I;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    if (!d_wr_q) begin
                        d_rdata_d = l2_rdata;
                    end
                    state_d = RESP_D;
                end
            end
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign l2_read  = (state_q == SERVE_I) || ((state_q == SERVE_D) && !d_wr_q);
    assign l2_write = (state_q == SERVE_D) && d_wr_q;
    assign l2_addr  = l2_addr_q;
    assign l2_wdata = l2_wdata_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign i_resp   = (state_q == RESP_I);
    assign d_resp   = (state_q == RESP_D);

endmodule

// File: tb/tb_l1_arbiter.sv
// Bench for l1_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_l1_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, l2_resp = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [LW-1:0] d_wdata = '0, l2_rdata = '0;
    logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
    logic [AW-1:0] l2_addr;
    logic          i_resp, d_resp, l2_read, l2_write;

    l1_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the L2 port (0 none, 1 icache, 2 dcache) and who is owed a response.
    int            m_busy, m_resp, m_last;
    bit            m_wr, m_ip, m_dp;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_ird, m_drd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_resp = 0; m_last = 1; m_wr = 0;
            m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
        end else if (m_resp != 0) begin
            m_resp = 0;
        end else if (m_busy != 0) begin
            if (l2_resp) begin
                if (m_busy == 1) m_ird = l2_rdata;
                else if (!m_wr) m_drd = l2_rdata;
                m_resp = m_busy;
                m_busy = 0;
            end
        end else begin
            m_ip = i_read;
            m_dp = d_read | d_write;
            if (m_ip && m_dp) m_busy = (m_last == 1) ? 2 : 1;
            else if (m_ip)    m_busy = 1;
            else if (m_dp)    m_busy = 2;
            if (m_busy != 0) begin
                m_last = m_busy;
                if (m_busy == 1) begin
                    m_addr = i_addr;
                end else begin
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                    m_wr    = d_write;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("l2_read",  l2_read,  (m_busy == 1) || (m_busy == 2 && !m_wr));
        chk("l2_write", l2_write, (m_busy == 2) && m_wr);
        chk("l2_addr",  l2_addr,  m_addr);
        chk("l2_wdata", l2_wdata, m_wdata);
        chk("i_resp",   i_resp,   m_resp == 1);
        chk("d_resp",   d_resp,   m_resp == 2);
        chk("i_rdata",  i_rdata,  m_ird);
        chk("d_rdata",  d_rdata,  m_drd);
    end

    int c_rd, c_wr, c_ir, c_dr;
    always @(posedge clk) begin
        if (rst_n) begin
            c_rd += int'(l2_read);
            c_wr += int'(l2_write);
            c_ir += int'(i_resp);
            c_dr += int'(d_resp);
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        c_rd = 0; c_wr = 0; c_ir = 0; c_dr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        nclk(2);
        rst_n = 1'b1;
        nclk(1);
    endtask

    logic [LW-1:0] w1, w2, r1, r2, r3, r4, r5, r6;

    initial begin
        w1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        w2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        r1 = {16{8'h11}}; r2 = {16{8'h22}}; r3 = {16{8'h33}};
        r4 = {16{8'h44}}; r5 = {16{8'h55}}; r6 = {16{8'h66}};
        clr();
        nclk(2);
        rst_n = 1'b1;
        nclk(1);
        chk("rst_l2_addr", l2_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_l2_read", l2_read, 0);

        // Single icache fill, L2 answers in the third SERVE cycle.
        clr();
        i_read = 1; i_addr = 16'h1230;
        nclk(1);
        chk("t1_addr", l2_addr, 16'h1230);
        nclk(2);
        l2_resp = 1; l2_rdata = {16{8'hA5}};
        nclk(1);
        l2_resp = 0;
        chk("t1_iresp", i_resp, 1);
        chk("t1_irdata", i_rdata, {16{8'hA5}});
        i_read = 0;
        nclk(2);
        chk("t1_rd_cycles", c_rd, 3);
        chk("t1_iresp_cnt", c_ir, 1);
        chk("t1_dresp_cnt", c_dr, 0);

        // Dcache writeback with immediate l2_resp held into the response cycle.
        clr();
        d_write = 1; d_addr = 16'h8000; d_wdata = w1;
        nclk(1);
        chk("t2_wr", l2_write, 1);
        chk("t2_wdata", l2_wdata, w1);
        l2_resp = 1; l2_rdata = '1;
        nclk(1);
        chk("t2_dresp", d_resp, 1);
        chk("t2_drdata_kept", d_rdata, 0);
        l2_resp = 0; d_write = 0;
        nclk(2);
        chk("t2_wr_cycles", c_wr, 1);
        chk("t2_dresp_cnt", c_dr, 1);

        // Tie after reset goes to D, then I, then D alone, then a tie goes to I.
        do_reset();
        i_read = 1; i_addr = 16'h1111; d_read = 1; d_addr = 16'h2222;
        nclk(1);
        chk("t3_tie1_d", l2_addr, 16'h2222);
        l2_resp = 1; l2_rdata = r1;
        nclk(1);
        l2_resp = 0; d_read = 0;
        chk("t3_dresp", d_resp, 1);
        nclk(2);
        chk("t3_then_i", l2_addr, 16'h1111);
        l2_resp = 1; l2_rdata = r2;
        nclk(1);
        l2_resp = 0; i_read = 0;
        nclk(1);
        d_read = 1; d_addr = 16'h3333;
        nclk(1);
        l2_resp = 1; l2_rdata = r4;
        nclk(1);
        l2_resp = 0; d_read = 0;
        nclk(1);
        i_read = 1; i_addr = 16'h4444; d_read = 1; d_addr = 16'h5555;
        nclk(1);
        chk("t3_tie2_i", l2_addr, 16'h4444);
        l2_resp = 1; l2_rdata = r3;
        nclk(1);
        l2_resp = 0; i_read = 0;
        nclk(2);
        chk("t3_then_d", l2_addr, 16'h5555);
        l2_resp = 1; l2_rdata = r5;
        nclk(1);
        l2_resp = 0; d_read = 0;
        nclk(1);

        // Read+write together: write wins; inputs wobble during SERVE_D; read follows.
        d_read = 1; d_write = 1; d_addr = 16'h6000; d_wdata = w2;
        nclk(1);
        d_addr = 16'h7777; d_wdata = ~w2;
        nclk(1);
        chk("t4_addr_hold", l2_addr, 16'h6000);
        chk("t4_wdata_hold", l2_wdata, w2);
        chk("t4_write_wins", l2_write, 1);
        l2_resp = 1; l2_rdata = r6;
        nclk(1);
        l2_resp = 0; d_write = 0;
        chk("t4_drdata_kept", d_rdata, r5);
        nclk(2);
        chk("t4_read_after", l2_read, 1);
        chk("t4_read_addr", l2_addr, 16'h7777);
        l2_resp = 1;
        nclk(1);
        l2_resp = 0; d_read = 0;
        chk("t4_drdata_new", d_rdata, r6);
        nclk(1);

        // Stray l2_resp in IDLE.
        clr();
        l2_resp = 1; l2_rdata = '0;
        nclk(1);
        l2_resp = 0;
        nclk(2);
        chk("t5_no_resp", c_ir + c_dr, 0);
        chk("t5_no_cmd", c_rd + c_wr, 0);

        // Reset in the middle of an icache fill.
        clr();
        i_read = 1; i_addr = 16'h9ABC;
        nclk(2);
        #2;
        rst_n = 1'b0;
        i_read = 0;
        #1;
        chk("t6_async_rd", l2_read, 0);
        chk("t6_async_addr", l2_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nclk(4);
        chk("t6_no_iresp", c_ir, 0);
        chk("t6_idle", l2_read, 0);

        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
